controlador_interrupcao: RTL and testbench

Sequences the processor's interrupt path between the user program and the OS kernel. It owns the preemption quantum timer, latches halt, quantum-expiry and I/O-button interrupt requests, and arbitrates them by fixed priority. It dispatches one interrupt at a time to the PC/control logic and holds the kernel in a masked mode until the OS returns. It sits between the control unit (halt, set_clock, get_interruption, os return) and the PC module / register-file write mux.

---
 rtl/controlador_interrupcao.sv | 134 +++++++++++++
 tb/tb_controlador_interrupcao.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/controlador_interrupcao.sv
// Interrupt sequencer between the user program and the OS kernel: quantum timer,
// edge-latched halt/io requests, fixed-priority dispatch (halt > clk > io), masked kernel mode.
module controlador_interrupcao #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int TIME_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  halt_req,
  input  logic                  io_req,
  input  logic                  set_clock,
  input  logic [TIME_WIDTH-1:0] int_time,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] pc_proximo,
  input  logic                  get_interruption,
  input  logic                  os_return,
  output logic                  int_halt,
  output logic                  int_clk,
  output logic                  int_io,
  output logic [DATA_WIDTH-1:0] qual_interrupcao,
  output logic [ADDR_WIDTH-1:0] pc_interrup,
  output logic                  kernel_mode,
  output logic [TIME_WIDTH-1:0] quantum_restante
);

  typedef enum logic [1:0] {ST_USER, ST_DISPATCH, ST_KERNEL} state_t;

  state_t r_state, w_next_state;

  logic                  r_halt_d, r_io_d;
  logic                  r_pend_halt, r_pend_clk, r_pend_io;
  logic                  r_armed;
  logic [TIME_WIDTH-1:0] r_count;
  logic                  r_int_halt, r_int_clk, r_int_io;
  logic [DATA_WIDTH-1:0] r_qual;
  logic [ADDR_WIDTH-1:0] r_pc_int;

  logic       w_halt_rise, w_io_rise, w_expire, w_any_pend, w_enter_dispatch;
  logic       w_sel_halt, w_sel_clk, w_sel_io;
  logic [1:0] w_code;

  assign w_halt_rise = halt_req & ~r_halt_d;
  assign w_io_rise   = io_req & ~r_io_d;
  // Timer only runs in user mode; a reload in the same cycle suppresses expiry.
  assign w_expire    = r_armed && (r_state == ST_USER) && !set_clock && (r_count == TIME_WIDTH'(1));

  assign w_any_pend       = r_pend_halt | r_pend_clk | r_pend_io;
  assign w_enter_dispatch = (r_state == ST_USER) && w_any_pend;

  assign w_sel_halt = r_pend_halt;
  assign w_sel_clk  = ~r_pend_halt & r_pend_clk;
  assign w_sel_io   = ~r_pend_halt & ~r_pend_clk & r_pend_io;
  assign w_code     = w_sel_halt ? 2'd2 : (w_sel_clk ? 2'd1 : (w_sel_io ? 2'd3 : 2'd0));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_USER:     if (w_any_pend) w_next_state = ST_DISPATCH;
      ST_DISPATCH: w_next_state = ST_KERNEL;
      ST_KERNEL:   if (os_return) w_next_state = ST_USER;
      default:     w_next_state = ST_USER;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_USER;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_armed <= 1'b0;
    end else if (set_clock) begin
      r_count <= int_time;
      r_armed <= (int_time != '0);
    end else if (r_armed && (r_state == ST_USER)) begin
      r_count <= r_count - TIME_WIDTH'(1);
      if (r_count == TIME_WIDTH'(1)) r_armed <= 1'b0;
    end
  end

  // A new request on the same edge as its dispatch-clear stays pending.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_halt_d    <= 1'b0;
      r_io_d      <= 1'b0;
      r_pend_halt <= 1'b0;
      r_pend_clk  <= 1'b0;
      r_pend_io   <= 1'b0;
    end else begin
      r_halt_d    <= halt_req;
      r_io_d      <= io_req;
      r_pend_halt <= (r_pend_halt & ~(w_enter_dispatch & w_sel_halt)) | w_halt_rise;
      r_pend_clk  <= (r_pend_clk  & ~(w_enter_dispatch & w_sel_clk))  | w_expire;
      r_pend_io   <= (r_pend_io   & ~(w_enter_dispatch & w_sel_io))   | w_io_rise;
    end
  end

  // Dispatch results are captured on the edge into DISPATCH so they are visible during it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_int_halt <= 1'b0;
      r_int_clk  <= 1'b0;
      r_int_io   <= 1'b0;
      r_qual     <= '0;
      r_pc_int   <= '0;
    end else if (w_enter_dispatch) begin
      r_int_halt <= w_sel_halt;
      r_int_clk  <= w_sel_clk;
      r_int_io   <= w_sel_io;
      r_qual     <= DATA_WIDTH'(w_code);
      r_pc_int   <= w_sel_halt ? pc : pc_proximo;
    end else begin
      r_int_halt <= 1'b0;
      r_int_clk  <= 1'b0;
      r_int_io   <= 1'b0;
      if ((r_state == ST_KERNEL) && get_interruption) r_qual <= '0;
    end
  end

  assign int_halt         = r_int_halt;
  assign int_clk          = r_int_clk;
  assign int_io           = r_int_io;
  assign qual_interrupcao = r_qual;
  assign pc_interrup      = r_pc_int;
  assign kernel_mode      = (r_state != ST_USER);
  assign quantum_restante = r_count;

endmodule

// File: tb/tb_controlador_interrupcao.sv
// Directed bench for controlador_interrupcao: timer expiry, priority, kernel masking,
// set_clock races, disarm and asynchronous reset from kernel mode.
module tb_controlador_interrupcao;

  logic        clock = 1'b0;
  logic        reset_n, halt_req, io_req, set_clock, get_interruption, os_return;
  logic [15:0] int_time;
  logic [12:0] pc, pc_proximo;
  logic        int_halt, int_clk, int_io, kernel_mode;
  logic [31:0] qual_interrupcao;
  logic [12:0] pc_interrup;
  logic [15:0] quantum_restante;

  int checks = 0;
  int errors = 0;

  controlador_interrupcao dut (
    .clock(clock), .reset_n(reset_n), .halt_req(halt_req), .io_req(io_req),
    .set_clock(set_clock), .int_time(int_time), .pc(pc), .pc_proximo(pc_proximo),
    .get_interruption(get_interruption), .os_return(os_return),
    .int_halt(int_halt), .int_clk(int_clk), .int_io(int_io),
    .qual_interrupcao(qual_interrupcao), .pc_interrup(pc_interrup),
    .kernel_mode(kernel_mode), .quantum_restante(quantum_restante)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic finish_kernel();
    get_interruption = 1'b1;
    step();
    get_interruption = 1'b0;
    os_return = 1'b1;
    step();
    os_return = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; halt_req = 1'b0; io_req = 1'b0; set_clock = 1'b0; int_time = '0;
    get_interruption = 1'b0; os_return = 1'b0; pc = 13'h100; pc_proximo = 13'h104;
    step(); step();
    chk("rst_kernel", 32'(kernel_mode), 32'd0);
    chk("rst_ints", {29'd0, int_halt, int_clk, int_io}, 32'd0);
    chk("rst_qual", qual_interrupcao, 32'd0);
    chk("rst_pcint", 32'(pc_interrup), 32'd0);
    chk("rst_quantum", 32'(quantum_restante), 32'd0);
    reset_n = 1'b1;
    step();

    // quantum of 5 expires and dispatches clk
    set_clock = 1'b1; int_time = 16'd5;
    step();
    set_clock = 1'b0;
    chk("q_load5", 32'(quantum_restante), 32'd5);
    for (int v = 4; v >= 0; v--) begin
      step();
      chk("q_count", 32'(quantum_restante), 32'(v));
    end
    chk("q_pre_dispatch_kernel", 32'(kernel_mode), 32'd0);
    chk("q_pre_dispatch_intclk", 32'(int_clk), 32'd0);
    step();
    chk("q_int_clk", 32'(int_clk), 32'd1);
    chk("q_code", qual_interrupcao, 32'd1);
    chk("q_pcint", 32'(pc_interrup), 32'h104);
    chk("q_kernel", 32'(kernel_mode), 32'd1);
    step();
    chk("q_int_clk_pulse", 32'(int_clk), 32'd0);
    chk("q_kernel_hold", 32'(kernel_mode), 32'd1);
    get_interruption = 1'b1;
    step();
    get_interruption = 1'b0;
    chk("q_get_clears", qual_interrupcao, 32'd0);
    chk("q_pcint_kept", 32'(pc_interrup), 32'h104);
    os_return = 1'b1;
    step();
    os_return = 1'b0;
    chk("q_return_user", 32'(kernel_mode), 32'd0);
    step();
    chk("q_idle_user", 32'(kernel_mode), 32'd0);

    // halt and timer expiry on the same edge
    set_clock = 1'b1; int_time = 16'd2;
    step();
    set_clock = 1'b0;
    step();
    chk("hc_count1", 32'(quantum_restante), 32'd1);
    halt_req = 1'b1;
    step();
    chk("hc_count0", 32'(quantum_restante), 32'd0);
    step();
    chk("hc_int_halt", 32'(int_halt), 32'd1);
    chk("hc_no_int_clk", 32'(int_clk), 32'd0);
    chk("hc_code2", qual_interrupcao, 32'd2);
    chk("hc_pcint_pc", 32'(pc_interrup), 32'h100);
    halt_req = 1'b0;
    step();
    get_interruption = 1'b1;
    step();
    get_interruption = 1'b0;
    chk("hc_get_clears", qual_interrupcao, 32'd0);
    chk("hc_pcint_kept", 32'(pc_interrup), 32'h100);
    os_return = 1'b1;
    step();
    os_return = 1'b0;
    chk("hc_user_cycle", 32'(kernel_mode), 32'd0);
    chk("hc_user_no_clk", 32'(int_clk), 32'd0);
    step();
    chk("hc_int_clk", 32'(int_clk), 32'd1);
    chk("hc_code1", qual_interrupcao, 32'd1);
    chk("hc_pcint_prox", 32'(pc_interrup), 32'h104);
    finish_kernel();

    // io edge inside kernel is masked until return; held level dispatches once
    halt_req = 1'b1;
    step(); step(); step();
    chk("io_in_kernel", 32'(kernel_mode), 32'd1);
    halt_req = 1'b0;
    io_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("io_masked", {30'd0, int_io, kernel_mode}, 32'd1);
    end
    get_interruption = 1'b1;
    step();
    get_interruption = 1'b0;
    os_return = 1'b1;
    step();
    os_return = 1'b0;
    chk("io_user", 32'(kernel_mode), 32'd0);
    step();
    chk("io_int_io", 32'(int_io), 32'd1);
    chk("io_code3", qual_interrupcao, 32'd3);
    chk("io_pcint", 32'(pc_interrup), 32'h104);
    step();
    chk("io_pulse", 32'(int_io), 32'd0);
    finish_kernel();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("io_held_once", {30'd0, int_io, kernel_mode}, 32'd0);
    end
    io_req = 1'b0;

    // reload on the expiry cycle suppresses the interrupt
    set_clock = 1'b1; int_time = 16'd2;
    step();
    set_clock = 1'b0;
    step();
    chk("rl_count1", 32'(quantum_restante), 32'd1);
    set_clock = 1'b1; int_time = 16'd3;
    step();
    set_clock = 1'b0;
    chk("rl_count3", 32'(quantum_restante), 32'd3);
    step();
    chk("rl_count2", 32'(quantum_restante), 32'd2);
    chk("rl_no_dispatch", {30'd0, int_clk, kernel_mode}, 32'd0);
    set_clock = 1'b1; int_time = 16'd0;
    step();
    set_clock = 1'b0;

    // int_time = 0 disarms an armed timer
    set_clock = 1'b1; int_time = 16'd7;
    step();
    chk("da_count7", 32'(quantum_restante), 32'd7);
    int_time = 16'd0;
    step();
    set_clock = 1'b0;
    chk("da_count0", 32'(quantum_restante), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("da_quiet", {14'd0, quantum_restante, 1'b0, int_clk, kernel_mode}, 32'd0);
    end

    // asynchronous reset from kernel mode with io pending
    halt_req = 1'b1;
    step(); step(); step();
    halt_req = 1'b0;
    io_req = 1'b1;
    set_clock = 1'b1; int_time = 16'd9;
    step();
    io_req = 1'b0; set_clock = 1'b0;
    step();
    chk("rk_kernel", 32'(kernel_mode), 32'd1);
    chk("rk_quantum9", 32'(quantum_restante), 32'd9);
    reset_n = 1'b0;
    #1;
    chk("rk_async_kernel", 32'(kernel_mode), 32'd0);
    chk("rk_async_qual", qual_interrupcao, 32'd0);
    chk("rk_async_pcint", 32'(pc_interrup), 32'd0);
    chk("rk_async_quantum", 32'(quantum_restante), 32'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rk_no_io", {29'd0, int_halt, int_io, kernel_mode}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
